// File: rtl/four_bank_mem_if.sv
// Request/response bundle between the cache controller (master) and the
// four-bank interleaved memory (slave).
interface four_bank_mem_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 16
);
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data_in;
   logic              rd;
   logic              wr;
   logic [DATA_W-1:0] data_out;
   logic              data_valid;
   logic              stall;
   logic [3:0]        busy;
   logic              err;

   modport master (
      output addr, data_in, rd, wr,
      input  data_out, data_valid, stall, busy, err
   );

   modport slave (
      input  addr, data_in, rd, wr,
      output data_out, data_valid, stall, busy, err
   );
endinterface

// File: rtl/four_bank_mem.sv
// Four-way interleaved word memory: per-bank 3-cycle busy window and a fixed
// two-stage read return pipeline, so consecutive-bank reads stream one word/cycle.
module four_bank_mem #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ROWS   = 64
) (
   input  logic           clk,
   input  logic           rst,
   four_bank_mem_if.slave bus
);
   localparam int unsigned BANKS     = 4;
   localparam int unsigned ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int unsigned CNT_W     = 2;
   localparam logic [CNT_W-1:0] BUSY_LOAD = CNT_W'(3);

   logic [1:0]        bank_c;
   logic [ROW_W-1:0]  row_c;
   logic              legal_c;
   logic              bank_busy_c;
   logic              accept_c;
   logic              unused_addr_c;

   logic [CNT_W-1:0]  cnt [BANKS];
   logic [DATA_W-1:0] mem [BANKS][ROWS];
   logic              s1_valid;
   logic              s2_valid;
   logic [DATA_W-1:0] s1_data;
   logic [DATA_W-1:0] s2_data;

   // Request decode: exactly one of rd/wr, word-aligned, and target bank idle.
   always_comb begin
      bank_c      = bus.addr[2:1];
      row_c       = bus.addr[3 +: ROW_W];
      legal_c     = (bus.rd ^ bus.wr) & ~bus.addr[0];
      bank_busy_c = (cnt[bank_c] != '0);
      accept_c    = legal_c & ~bank_busy_c;
   end

   assign unused_addr_c = ^bus.addr;

   assign bus.err   = (bus.rd | bus.wr) & ~legal_c;
   assign bus.stall = legal_c & bank_busy_c;

   // Per-bank busy counters: load on accept, count down to idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int n = 0; n < BANKS; n++) cnt[n] <= '0;
      end else begin
         for (int n = 0; n < BANKS; n++) begin
            if (accept_c && (bank_c == 2'(n))) cnt[n] <= BUSY_LOAD;
            else if (cnt[n] != '0)             cnt[n] <= cnt[n] - CNT_W'(1);
         end
      end
   end

   // Storage array; cleared by reset so pre-reset writes are lost.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < BANKS; b++)
            for (int r = 0; r < ROWS; r++)
               mem[b][r] <= '0;
      end else if (accept_c && bus.wr) begin
         mem[bank_c][row_c] <= bus.data_in;
      end
   end

   // Read return pipeline; invalid stages carry zero so data_out needs no mux.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s2_valid <= 1'b0;
         s2_data  <= '0;
      end else begin
         s1_valid <= accept_c & bus.rd;
         s1_data  <= (accept_c && bus.rd) ? mem[bank_c][row_c] : '0;
         s2_valid <= s1_valid;
         s2_data  <= s1_data;
      end
   end

   assign bus.data_out   = s2_data;
   assign bus.data_valid = s2_valid;

   always_comb begin
      bus.busy = '0;
      for (int n = 0; n < BANKS; n++) bus.busy[n] = (cnt[n] != '0);
   end
endmodule

// File: tb/tb_four_bank_mem.sv
// Self-checking bench for four_bank_mem: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a model.
module tb_four_bank_mem;
   localparam int unsigned AW = 16;
   localparam int unsigned DW = 16;
   localparam int unsigned NR = 64;

   logic clk = 1'b0;
   logic rst;

   four_bank_mem_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   four_bank_mem #(.ADDR_W(AW), .DATA_W(DW), .ROWS(NR)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: each bank is free again at a known edge number, and
   // each accepted read is due on the output one edge after acceptance.
   typedef struct {
      int          due;
      logic [15:0] d;
   } rd_t;

   logic [15:0] mmem [4][NR];
   int          free_at [4];
   int          k = 0;
   rd_t         q[$];
   int          m_b;
   int          m_r;

   function automatic logic f_legal(input logic r, input logic w, input logic [15:0] a);
      return (r != w) && !a[0];
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         k = 0;
         q.delete();
         for (int b = 0; b < 4; b++) begin
            free_at[b] = 0;
            for (int r = 0; r < NR; r++) mmem[b][r] = 16'h0;
         end
      end else begin
         k++;
         m_b = int'(bus.addr[2:1]);
         m_r = int'(bus.addr[8:3]);
         if (f_legal(bus.rd, bus.wr, bus.addr) && k >= free_at[m_b]) begin
            free_at[m_b] = k + 4;
            if (bus.rd) q.push_back('{due: k + 1, d: mmem[m_b][m_r]});
            else        mmem[m_b][m_r] = bus.data_in;
         end
         while (q.size() > 0 && q[0].due < k) void'(q.pop_front());
      end
   end

   logic        exp_v;
   logic [15:0] exp_d;
   logic [3:0]  exp_busy;
   logic        exp_leg;
   logic        exp_req;

   // Per-cycle comparison, mid-cycle, against the model.
   always @(negedge clk) begin
      exp_v = (q.size() > 0) && (q[0].due == k);
      exp_d = exp_v ? q[0].d : 16'h0;
      for (int n = 0; n < 4; n++) exp_busy[n] = (k < free_at[n] - 1);
      exp_req = bus.rd | bus.wr;
      exp_leg = f_legal(bus.rd, bus.wr, bus.addr);
      chk("cmp_data_valid", 32'(bus.data_valid), 32'(exp_v));
      chk("cmp_data_out",   32'(bus.data_out),   32'(exp_d));
      chk("cmp_busy",       32'(bus.busy),       32'(exp_busy));
      chk("cmp_stall",      32'(bus.stall),      32'(exp_leg & exp_busy[bus.addr[2:1]]));
      chk("cmp_err",        32'(bus.err),        32'(exp_req & ~exp_leg));
   end

   task automatic drive(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
      @(posedge clk);
      #1;
      bus.rd      = r;
      bus.wr      = w;
      bus.addr    = a;
      bus.data_in = d;
   endtask

   task automatic drive_idle();
      drive(1'b0, 1'b0, 16'h0, 16'h0);
   endtask

   logic [15:0] got[$];
   logic [15:0] fill_w [4];
   int          first_v;
   int          last_v;
   int          n_st;
   int          nv;
   logic        acc;
   logic [15:0] ra;
   int          sel;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      fill_w[0] = 16'h1111;
      fill_w[1] = 16'h2222;
      fill_w[2] = 16'h3333;
      fill_w[3] = 16'h4444;
      bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = 16'h0; bus.data_in = 16'h0;
      rst = 1'b0;
      #1 rst = 1'b1;
      @(negedge clk);
      chk("rst_busy",       32'(bus.busy),       32'h0);
      chk("rst_data_valid", 32'(bus.data_valid), 32'h0);
      chk("rst_data_out",   32'(bus.data_out),   32'h0);
      #1 rst = 1'b0;

      // Single write then read-back of bank 1.
      drive(1'b0, 1'b1, 16'h0002, 16'hBEEF);
      drive_idle();
      @(negedge clk); chk("wr_busy_t1", 32'(bus.busy), 32'h2);
      @(negedge clk); chk("wr_busy_t2", 32'(bus.busy), 32'h2);
      @(negedge clk); chk("wr_busy_t3", 32'(bus.busy), 32'h2);
      @(negedge clk); chk("wr_busy_t4", 32'(bus.busy), 32'h0);
      drive(1'b1, 1'b0, 16'h0002, 16'h0);
      drive_idle();
      @(negedge clk); chk("rd_lat1_valid", 32'(bus.data_valid), 32'h0);
      @(negedge clk); chk("rd_lat2_valid", 32'(bus.data_valid), 32'h1);
                      chk("rd_lat2_data",  32'(bus.data_out),   32'hBEEF);
      @(negedge clk); chk("rd_after_valid", 32'(bus.data_valid), 32'h0);

      // Line fill across all four banks.
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 16'h0010 + 16'(2 * i), fill_w[i]);
      drive_idle();
      repeat (4) @(negedge clk);
      first_v = -1; last_v = -1;
      fork
         begin
            for (int i = 0; i < 4; i++) begin
               drive(1'b1, 1'b0, 16'h0010 + 16'(2 * i), 16'h0);
               @(negedge clk);
               chk("fill_stall", 32'(bus.stall), 32'h0);
            end
            drive_idle();
         end
         begin
            for (int j = 0; j < 10; j++) begin
               @(negedge clk);
               if (bus.data_valid) begin
                  got.push_back(bus.data_out);
                  if (first_v < 0) first_v = j;
                  last_v = j;
               end
            end
         end
      join
      chk("fill_count",  32'(got.size()), 32'd4);
      chk("fill_consec", 32'(last_v - first_v), 32'd3);
      for (int i = 0; i < 4 && i < got.size(); i++) chk("fill_word", 32'(got[i]), 32'(fill_w[i]));

      // Same-bank conflict on bank 2.
      drive(1'b0, 1'b1, 16'h000C, 16'h5A5A);
      drive_idle();
      repeat (4) @(negedge clk);
      drive(1'b1, 1'b0, 16'h0004, 16'h0);
      drive(1'b1, 1'b0, 16'h000C, 16'h0);
      n_st = 0; acc = 1'b0;
      for (int i = 0; i < 8 && !acc; i++) begin
         @(negedge clk);
         if (bus.stall) n_st++;
         else           acc = 1'b1;
      end
      chk("conf_stall_cycles", 32'(n_st), 32'd3);
      drive_idle();
      @(negedge clk); chk("conf_lat1_valid", 32'(bus.data_valid), 32'h0);
      @(negedge clk); chk("conf_lat2_valid", 32'(bus.data_valid), 32'h1);
                      chk("conf_lat2_data",  32'(bus.data_out),   32'h5A5A);

      // Illegal requests change nothing.
      drive(1'b0, 1'b1, 16'h0000, 16'h7777);
      drive_idle();
      repeat (4) @(negedge clk);
      drive(1'b1, 1'b1, 16'h0000, 16'h0);
      @(negedge clk); chk("ill_rdwr_err", 32'(bus.err), 32'h1);
                      chk("ill_rdwr_stall", 32'(bus.stall), 32'h0);
      drive_idle();
      @(negedge clk); chk("ill_rdwr_busy", 32'(bus.busy), 32'h0);
      drive(1'b0, 1'b1, 16'h0001, 16'hDEAD);
      @(negedge clk); chk("ill_odd_err", 32'(bus.err), 32'h1);
      drive_idle();
      @(negedge clk); chk("ill_odd_busy", 32'(bus.busy), 32'h0);
      drive(1'b1, 1'b0, 16'h0000, 16'h0);
      drive_idle();
      @(negedge clk);
      @(negedge clk); chk("ill_keep_valid", 32'(bus.data_valid), 32'h1);
                      chk("ill_keep_data",  32'(bus.data_out),   32'h7777);

      // Reset while a read is in flight.
      drive(1'b1, 1'b0, 16'h0002, 16'h0);
      drive_idle();
      #1 rst = 1'b1;
      #1 chk("rstmid_busy", 32'(bus.busy), 32'h0);
      @(negedge clk);
      #1 rst = 1'b0;
      nv = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus.data_valid) nv++;
      end
      chk("rstmid_no_valid", 32'(nv), 32'd0);
      drive(1'b1, 1'b0, 16'h0002, 16'h0);
      drive_idle();
      @(negedge clk);
      @(negedge clk); chk("rstmid_valid", 32'(bus.data_valid), 32'h1);
                      chk("rstmid_data",  32'(bus.data_out),   32'h0);

      // Write-back burst over all banks, then a bank-0 read right behind it.
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 16'h0020 + 16'(2 * i), 16'hA000 + 16'(i));
      drive(1'b1, 1'b0, 16'h0020, 16'h0);
      @(negedge clk); chk("wb_busy", 32'(bus.busy), 32'hE);
                      chk("wb_rd_stall", 32'(bus.stall), 32'h0);
      drive_idle();
      @(negedge clk);
      @(negedge clk); chk("wb_rd_valid", 32'(bus.data_valid), 32'h1);
                      chk("wb_rd_data",  32'(bus.data_out),   32'hA000);

      // Randomized traffic; the per-cycle comparison does the checking.
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         #1;
         if ($urandom_range(0, 599) == 0) begin
            bus.rd = 1'b0; bus.wr = 1'b0;
            rst = 1'b1;
            @(negedge clk);
            #1 rst = 1'b0;
         end else begin
            ra  = 16'($urandom_range(0, 16'h3F));
            sel = int'($urandom_range(0, 19));
            if (sel != 19) ra[0] = 1'b0;
            bus.addr    = ra;
            bus.data_in = 16'($urandom);
            bus.rd      = (sel >= 4 && sel < 11) || sel == 18;
            bus.wr      = (sel >= 11 && sel < 19);
         end
      end
      drive_idle();
      repeat (6) @(negedge clk);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end
endmodule
